// File: rtl/axis_word_packer.sv
// axis_word_packer
// Gathers a narrow AXI-Stream word stream into wide blocks of C_WORDS words.
// A block is emitted when it fills up or when tlast closes it early; tkeep
// marks which word slots of the emitted block carry data.
module axis_word_packer #(
    parameter int C_WORD_WIDTH = 32,
    parameter int C_WORDS      = 16
) (
    input  logic                            i_aclk,
    input  logic                            i_areset,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tvalid,
    input  logic [C_WORD_WIDTH-1:0]         s_axis_tdata,
    input  logic                            s_axis_tlast,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tvalid,
    output logic [C_WORD_WIDTH*C_WORDS-1:0] m_axis_tdata,
    output logic [C_WORDS-1:0]              m_axis_tkeep,
    output logic                            m_axis_tlast
);

    localparam int CW       = $clog2(C_WORDS);
    localparam int ACC_BITS = C_WORD_WIDTH * (C_WORDS - 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(C_WORDS - 1);

    // Only C_WORDS-1 words need storing: the final word of a block goes
    // straight from the input into the output register.
    logic [ACC_BITS-1:0]              acc;
    logic [CW-1:0]                    count;

    logic                             accept;
    logic                             completing;
    logic [C_WORD_WIDTH*C_WORDS-1:0]  next_block;
    logic [C_WORDS-1:0]               next_keep;

    // A new word may enter whenever the output register is empty or draining.
    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign completing    = (count == LAST_IDX) || s_axis_tlast;

    // Assemble the block that a completing word would produce: stored words
    // below the counter, the incoming word at the counter, zeros above.
    always_comb begin
        next_block = '0;
        next_keep  = '0;
        for (int i = 0; i < C_WORDS - 1; i++) begin
            if (i < int'(count)) begin
                next_block[i*C_WORD_WIDTH +: C_WORD_WIDTH] = acc[i*C_WORD_WIDTH +: C_WORD_WIDTH];
            end
        end
        next_block[int'(count)*C_WORD_WIDTH +: C_WORD_WIDTH] = s_axis_tdata;
        for (int i = 0; i < C_WORDS; i++) begin
            next_keep[i] = (i <= int'(count));
        end
    end

    // Accumulate words, close blocks into the output register, and retire
    // the output beat when the sink takes it (a fresh block wins over retire).
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            acc           <= '0;
            count         <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (accept && completing) begin
                m_axis_tdata  <= next_block;
                m_axis_tkeep  <= next_keep;
                m_axis_tlast  <= s_axis_tlast;
                m_axis_tvalid <= 1'b1;
                acc           <= '0;
                count         <= '0;
            end else begin
                if (m_axis_tvalid && m_axis_tready) begin
                    m_axis_tvalid <= 1'b0;
                end
                if (accept) begin
                    acc[int'(count)*C_WORD_WIDTH +: C_WORD_WIDTH] <= s_axis_tdata;
                    count <= count + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_word_packer.sv
// tb_axis_word_packer
// Directed bench: stimulus pushes hand-derived expected blocks into a
// scoreboard queue; a monitor pops and compares every drained output beat.
module tb_axis_word_packer;

    localparam int W = 32;
    localparam int N = 16;

    logic               clk;
    logic               rst;
    logic               s_tready;
    logic               s_tvalid;
    logic [W-1:0]       s_tdata;
    logic               s_tlast;
    logic               m_tready;
    logic               m_tvalid;
    logic [W*N-1:0]     m_tdata;
    logic [N-1:0]       m_tkeep;
    logic               m_tlast;

    typedef struct {
        logic [W*N-1:0] d;
        logic [N-1:0]   k;
        logic           l;
    } beat_t;

    beat_t sb[$];
    int    beat_cyc[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    stall_cycles = 0;

    axis_word_packer #(.C_WORD_WIDTH(W), .C_WORDS(N)) dut (
        .i_aclk        (clk),
        .i_areset      (rst),
        .s_axis_tready (s_tready),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .m_axis_tready (m_tready),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast)
    );

    // Free-running clock and cycle counter used to time output beats.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case the design wedges somewhere no bounded wait covers.
    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: got timeout expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    task automatic checkOutput(input string name, input logic [W*N-1:0] act, input logic [W*N-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Block whose word i is base+i for i<n, zero above.
    function automatic logic [W*N-1:0] seqBlock(input logic [W-1:0] base, input int n);
        logic [W*N-1:0] b;
        b = '0;
        for (int i = 0; i < n; i++) b[i*W +: W] = base + W'(i);
        return b;
    endfunction

    task automatic pushExp(input logic [W*N-1:0] d, input logic [N-1:0] k, input logic l);
        beat_t b;
        b.d = d;
        b.k = k;
        b.l = l;
        sb.push_back(b);
    endtask

    // Offers one word and returns #1 after the edge that accepted it.
    task automatic applyStimulus(input logic [W-1:0] d, input logic l);
        int waitc;
        waitc = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        @(negedge clk);
        while (!s_tready && waitc < 200) begin
            waitc++;
            @(negedge clk);
        end
        stall_cycles += waitc;
        if (!s_tready) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL accept_timeout: got tready=0 expected tready=1");
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Scoreboard monitor: every beat handed over is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_beat", {{(W*N-1){1'b0}}, 1'b1}, '0);
            end else begin
                beat_t e;
                e = sb.pop_front();
                checkOutput("beat_tdata", m_tdata, e.d);
                checkOutput("beat_tkeep", {{(W*N-N){1'b0}}, m_tkeep}, {{(W*N-N){1'b0}}, e.k});
                checkOutput("beat_tlast", {{(W*N-1){1'b0}}, m_tlast}, {{(W*N-1){1'b0}}, e.l});
                beat_cyc.push_back(cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        #2;
        checkOutput("rst_tvalid", {511'b0, m_tvalid}, '0);
        checkOutput("rst_tdata", m_tdata, '0);
        checkOutput("rst_tkeep", {496'b0, m_tkeep}, '0);
        checkOutput("rst_tlast", {511'b0, m_tlast}, '0);
        checkOutput("rst_s_tready", {511'b0, s_tready}, 512'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] full block");
        pushExp(seqBlock(32'h0, 16), 16'hFFFF, 1'b1);
        for (int i = 0; i < 15; i++) applyStimulus(W'(i), 1'b0);
        checkOutput("full_valid_before", {511'b0, m_tvalid}, '0);
        applyStimulus(32'h0000000F, 1'b1);
        checkOutput("full_valid_after", {511'b0, m_tvalid}, 512'd1);
        idle(3);

        $display("[TB] partial packet");
        pushExp({416'b0, 32'hA3, 32'hA2, 32'hA1}, 16'h0007, 1'b1);
        applyStimulus(32'hA1, 1'b0);
        applyStimulus(32'hA2, 1'b0);
        applyStimulus(32'hA3, 1'b1);
        idle(3);

        $display("[TB] single word");
        pushExp({480'b0, 32'hDEADBEEF}, 16'h0001, 1'b1);
        applyStimulus(32'hDEADBEEF, 1'b1);
        idle(3);

        $display("[TB] backpressure");
        m_tready = 1'b0;
        pushExp(seqBlock(32'h100, 16), 16'hFFFF, 1'b1);
        for (int i = 0; i < 16; i++) applyStimulus(32'h100 + W'(i), i == 15);
        s_tvalid = 1'b1;
        s_tdata  = 32'h200;
        s_tlast  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("stall_s_tready", {511'b0, s_tready}, '0);
            checkOutput("stall_tdata", m_tdata, seqBlock(32'h100, 16));
            checkOutput("stall_tkeep", {496'b0, m_tkeep}, {496'b0, 16'hFFFF});
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        @(negedge clk);
        checkOutput("release_s_tready", {511'b0, s_tready}, 512'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        checkOutput("release_valid_drop", {511'b0, m_tvalid}, '0);
        pushExp(seqBlock(32'h200, 16), 16'hFFFF, 1'b1);
        for (int i = 1; i < 16; i++) applyStimulus(32'h200 + W'(i), i == 15);
        idle(3);

        $display("[TB] streaming");
        stall_cycles = 0;
        beat_cyc.delete();
        pushExp(seqBlock(32'h300, 16), 16'hFFFF, 1'b0);
        pushExp(seqBlock(32'h310, 16), 16'hFFFF, 1'b0);
        pushExp(seqBlock(32'h320, 16), 16'hFFFF, 1'b1);
        for (int i = 0; i < 48; i++) applyStimulus(32'h300 + W'(i), i == 47);
        idle(3);
        checkOutput("stream_stalls", 512'(stall_cycles), '0);
        checkOutput("stream_beats", 512'(beat_cyc.size()), 512'd3);
        if (beat_cyc.size() == 3) begin
            checkOutput("stream_gap1", 512'(beat_cyc[1] - beat_cyc[0]), 512'd16);
            checkOutput("stream_gap2", 512'(beat_cyc[2] - beat_cyc[1]), 512'd16);
        end

        $display("[TB] reset mid-block");
        for (int i = 0; i < 7; i++) applyStimulus(32'h400 + W'(i), 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("midrst_tvalid", {511'b0, m_tvalid}, '0);
        checkOutput("midrst_tdata", m_tdata, '0);
        checkOutput("midrst_tkeep", {496'b0, m_tkeep}, '0);
        checkOutput("midrst_tlast", {511'b0, m_tlast}, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        pushExp(seqBlock(32'h500, 16), 16'hFFFF, 1'b1);
        for (int i = 0; i < 16; i++) applyStimulus(32'h500 + W'(i), i == 15);
        idle(5);

        checkOutput("sb_drained", 512'(sb.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
